// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: instruction store with an integrated sequential fetch engine.
//
// Holds the program image written through the load port and streams
// instructions with their PC to the decoder over a valid/ready handshake.
// A synchronous memory read feeds a small prefetch FIFO. The FIFO sustains
// one instruction per cycle. A redirect input restarts fetch at a new PC.
//
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, error injection
// on write, error flag carried with each FIFO entry).
//
// Parameters:
//   LENGTH    instruction width in bits
//   IR_DEPTH  number of words (power of two, >= 4); AW = log2(IR_DEPTH)
//   PF_DEPTH  prefetch FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset (clears memory, FIFO, fetch PC)
//   test_normal  1 = load mode (fetch halted, writes allowed), 0 = run mode
//   ext_we       load write strobe (load mode only)
//   ext_addr     load write address
//   ext_data     load write data
//   redirect     run-mode PC redirect
//   redirect_pc  redirect target address
//   perr_inject  invert stored parity on write (IMEM_PARITY_EN only)
//   instr_valid  head entry valid
//   instr_ready  decoder accepts head entry
//   instruction  head instruction (holds last value when FIFO empty)
//   instr_pc     address of head instruction
//   parity_err   parity check failed for head entry (IMEM_PARITY_EN only)

module instr_fetch_mem #(
    parameter int unsigned LENGTH   = 16,
    parameter int unsigned IR_DEPTH = 32,
    parameter int unsigned PF_DEPTH = 2,
    localparam int unsigned AW      = $clog2(IR_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              test_normal,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [LENGTH-1:0] ext_data,
    input  logic              redirect,
    input  logic [AW-1:0]     redirect_pc,
`ifdef IMEM_PARITY_EN
    input  logic              perr_inject,
    output logic              parity_err,
`endif
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [LENGTH-1:0] instruction,
    output logic [AW-1:0]     instr_pc
);

    localparam int unsigned PTRW = $clog2(PF_DEPTH);
    localparam int unsigned CNTW = $clog2(PF_DEPTH + 1);
    localparam int unsigned OCCW = CNTW + 1;
    localparam logic [OCCW-1:0] PfDepthOcc = OCCW'(PF_DEPTH);

    // Storage
    logic [LENGTH-1:0] mem_q [IR_DEPTH];

    // Fetch engine
    logic [AW-1:0]     fetch_pc_q;
    logic              rd_vld_q;
    logic [LENGTH-1:0] rd_data_q;
    logic [AW-1:0]     rd_pc_q;

    // Prefetch FIFO
    logic [LENGTH-1:0] fifo_data_q [PF_DEPTH];
    logic [AW-1:0]     fifo_pc_q   [PF_DEPTH];
    logic [PTRW-1:0]   wr_ptr_q;
    logic [PTRW-1:0]   rd_ptr_q;
    logic [CNTW-1:0]   count_q;

    // Last presented head, shown while the FIFO is empty
    logic [LENGTH-1:0] hold_instr_q;
    logic [AW-1:0]     hold_pc_q;

    logic              flush;
    logic              fifo_nonempty;
    logic              pop;
    logic              push;
    logic [OCCW-1:0]   occ_after_pop;
    logic              issue;

    always_comb begin
        flush         = test_normal | redirect;
        fifo_nonempty = (count_q != '0);
        pop           = fifo_nonempty & instr_ready;
        push          = rd_vld_q;
        // Count the in-flight read as already occupying a slot so the FIFO
        // can never overflow, while a same-cycle pop frees room for a new issue.
        occ_after_pop = OCCW'(count_q) + OCCW'(rd_vld_q) - OCCW'(pop);
        issue         = !flush && (occ_after_pop < PfDepthOcc);
    end

    // Memory array: cleared by reset, written only in load mode
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < IR_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (test_normal && ext_we) begin
            mem_q[ext_addr] <= ext_data;
        end
    end

    // Fetch PC and synchronous read stage
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_pc_q    <= '0;
        end else begin
            if (test_normal) begin
                fetch_pc_q <= '0;
            end else if (redirect) begin
                fetch_pc_q <= redirect_pc;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + AW'(1);
            end
            // A flush drops any in-flight read because issue is low under flush
            rd_vld_q <= issue;
            if (issue) begin
                rd_data_q <= mem_q[fetch_pc_q];
                rd_pc_q   <= fetch_pc_q;
            end
        end
    end

    // Prefetch FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PF_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rd_data_q;
                fifo_pc_q[wr_ptr_q]   <= rd_pc_q;
                wr_ptr_q              <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNTW'(1);
            end
        end
    end

    // Output hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            hold_instr_q <= instruction;
            hold_pc_q    <= instr_pc;
        end
    end

    always_comb begin
        instr_valid = fifo_nonempty;
        instruction = fifo_nonempty ? fifo_data_q[rd_ptr_q] : hold_instr_q;
        instr_pc    = fifo_nonempty ? fifo_pc_q[rd_ptr_q]   : hold_pc_q;
    end

`ifdef IMEM_PARITY_EN
    logic mem_par_q  [IR_DEPTH];
    logic rd_err_q;
    logic fifo_err_q [PF_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < IR_DEPTH; i++) begin
                mem_par_q[i] <= 1'b0;
            end
            for (int unsigned i = 0; i < PF_DEPTH; i++) begin
                fifo_err_q[i] <= 1'b0;
            end
            rd_err_q <= 1'b0;
        end else begin
            if (test_normal && ext_we) begin
                mem_par_q[ext_addr] <= (^ext_data) ^ perr_inject;
            end
            if (issue) begin
                rd_err_q <= (^mem_q[fetch_pc_q]) ^ mem_par_q[fetch_pc_q];
            end
            if (!flush && push) begin
                fifo_err_q[wr_ptr_q] <= rd_err_q;
            end
        end
    end

    always_comb begin
        parity_err = fifo_nonempty & fifo_err_q[rd_ptr_q];
    end
`endif

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory with an integrated sequential fetch engine, the next generation of the core's instruction store. It holds the program image loaded through the external test/load port and streams instructions with their PC to the decoder over a valid/ready handshake. A small prefetch FIFO sustains one instruction per cycle, and a redirect input supports branches and jumps. The block sits between the program loader/testbench and the decode stage.

## Interface
- LENGTH, 16: instruction width in bits.
- IR_DEPTH, 32: number of words; power of two, at least 4. AW = log2(IR_DEPTH).
- PF_DEPTH, 2: prefetch FIFO entries; power of two, at least 2.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- test_normal  in  1  1 = load mode (fetch halted, writes allowed); 0 = run mode.
- ext_we  in  1  load write strobe; effective only when test_normal=1.
- ext_addr  in  AW  load write address.
- ext_data  in  LENGTH  load write data.
- redirect  in  1  run-mode PC redirect (branch/jump taken).
- redirect_pc  in  AW  target address for redirect.
- instr_valid  out  1  instruction/instr_pc are valid.
- instr_ready  in  1  decoder accepts the head entry when instr_valid=1.
- instruction  out  LENGTH  head-of-FIFO instruction word.
- instr_pc  out  AW  address the head instruction was read from.
- perr_inject  in  1  present only with IMEM_PARITY_EN; see Configuration.
- parity_err  out  1  present only with IMEM_PARITY_EN; see Configuration.

## Operation
- Reset: all memory words become 0, FIFO is empty, in-flight read is dropped, fetch_pc=0. Outputs: instr_valid=0, instruction=0, instr_pc=0, parity_err=0.
- Load mode (test_normal=1): ext_we=1 writes ext_data to mem[ext_addr]. Fetch is halted, the FIFO and any in-flight read are flushed every cycle, fetch_pc is held at 0, and instr_valid=0.
- Run mode: ext_we is ignored. The memory read is synchronous, with one read issued per cycle at fetch_pc. A read is issued when (FIFO occupancy + in-flight reads − pop this cycle) < PF_DEPTH.
- On issue, fetch_pc increments modulo IR_DEPTH, so IR_DEPTH−1 wraps to 0.
- Read data and its pc are pushed into the FIFO on the cycle after issue.
- Pop: an entry pops when instr_valid and instr_ready are both 1. A push and a pop in the same cycle are allowed, and occupancy is unchanged.
- Holding: while instr_valid=1 and instr_ready=0, instruction and instr_pc stay stable.
- Redirect (run mode only): the FIFO and the in-flight read are flushed, and fetch_pc is set to redirect_pc. A read of redirect_pc is issued in the next cycle.
- Redirect has priority over a same-cycle pop and push; the handshake in that cycle is still treated as consumed by the decoder.
- Load mode has priority over redirect.
- Empty FIFO: instr_valid=0 and instruction keeps its last value.

## Timing
- Cycle 0 is the first run-mode cycle after reset or load mode. The read of address 0 is issued in cycle 0, and instr_valid=1 in cycle 2 with mem[0] and pc 0.
- Redirect latency: redirect sampled in cycle N gives instr_valid=1 in cycle N+3 with mem[redirect_pc]. instr_valid=0 in cycles N+1 and N+2.
- Throughput: with instr_ready held at 1, one instruction per cycle after the initial latency, with no bubbles for PF_DEPTH≥2.
- Back-pressure: while instr_ready=0, the FIFO fills to PF_DEPTH and issue stops. At most PF_DEPTH instructions are buffered; no read is ever dropped or duplicated.
- Load to run: a word written in load-mode cycle K is readable from the first run-mode cycle.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed on write. When perr_inject=1 during the write, the stored parity bit is inverted.
  - Parity is rechecked on read and carried through the FIFO. parity_err is 1 alongside the head entry when the check fails, and 0 otherwise.
  - Reset clears all parity bits, so zero words are consistent.
- IMEM_PARITY_EN undefined: no parity storage, and the perr_inject and parity_err ports do not exist.

## Test plan
- Load mem[0..3]=16'h1111,16'h2222,16'h3333,16'h4444, then enter run mode with instr_ready=1 -> instr_valid first in cycle 2, then words 0..3 on consecutive cycles with instr_pc 0,1,2,3.
- Stream through address 31 with IR_DEPTH=32 -> after pc 31 comes pc 0 with mem[0]; no bubble.
- instr_ready=0 for 5 cycles mid-stream -> head is stable, the FIFO holds exactly 2 entries, and on release the pcs continue with no gap and no duplicate.
- Redirect to 10 while the FIFO is full and a pop occurs -> the flushed entries never appear, the next valid is pc 10 three cycles later, followed by 11 and 12.
- Assert reset mid-stream, then return to run mode -> instr_valid drops the next cycle, memory reads back 0, and fetch restarts at pc 0.
- With IMEM_PARITY_EN, write 16'hA5A5 to address 5 with perr_inject=1 and redirect to 5 -> parity_err=1 with that entry; a clean word gives parity_err=0.
